stl_arb_ingress_queue: RTL and testbench
========================================

# stl_arb_ingress_queue

Per-requester ingress buffering stage placed directly upstream of the matrix arbiter. It holds `REQ_N` independent FIFOs, one per requester, and presents their heads as the arbiter's valid/data request vectors. It tracks packet boundaries on the popped stream and drives the arbiter's `arb_keep`, so a multi-beat packet is never interleaved with another requester's beats.

## Interface
- `REQ_N`, 8: number of requester channels (≥2).
- `DAT_W`, 16: payload width per beat.
- `DEPTH`, 4: entries per channel FIFO; power of two, ≥2.
- `LW`, `$clog2(DEPTH)+1`: derived level width; do not override.

- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_vld_i`  in  REQ_N  per-channel write valid.
- `in_dat_i`  in  REQ_N×DAT_W  per-channel write payload.
- `in_last_i`  in  REQ_N  per-channel end-of-packet marker.
- `in_rdy_o`  out  REQ_N  per-channel write ready.
- `arb_vld_o`  out  REQ_N  FIFO head valid; connects to arbiter `req_vld_i`.
- `arb_dat_o`  out  REQ_N×(DAT_W+1)  FIFO head `{last, payload}`; last is the MSB; connects to arbiter `req_dat_i`.
- `arb_rdy_i`  in  REQ_N  per-channel pop; connects to arbiter `req_rdy_o`.
- `arb_keep_o`  out  1  packet-in-progress lock; connects to arbiter `arb_keep`. Arbiter is built with `KEEP_EN=1`.
- `lvl_o`  out  REQ_N×LW  per-channel occupancy, 0..DEPTH.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- Per-channel push occurs when `in_vld_i[i] && in_rdy_o[i]`. The beat `{in_last_i[i], in_dat_i[i]}` is written at the write pointer.
- Per-channel pop occurs when `arb_vld_o[i] && arb_rdy_i[i]`. The read pointer advances.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0. The level counter is a separate LW-bit count:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- `in_rdy_o[i] = (lvl[i] != DEPTH)`. It is a function of registered state only, with no combinational path from `arb_rdy_i`. A push and pop in the same cycle on a full FIFO does not occur, because ready is low.
- `arb_vld_o[i] = (lvl[i] != 0)`. `arb_dat_o[i]` is the storage entry at the read pointer. Its value is don't-care when not valid.
- Packet lock `keep` register:
  - Any pop with head last=0 sets `keep` to 1.
  - Any pop with head last=1 clears `keep` to 0.
  - No pop: hold.
  - `arb_keep_o = keep`.
- If the locked channel drains mid-packet, `keep` stays 1. The arbiter stalls because its `grt_vld_o` follows the kept channel's valid. No other channel may pop until the packet's last beat pops.
- `err_o` is set and held until reset when either condition occurs:
  - more than one pop in a cycle (`arb_vld_o & arb_rdy_i` not one-hot-or-zero);
  - a pop on channel j≠k while `keep=1`, where k is the channel of the last pop.
- The channel of the last pop is tracked in an internal register `keep_id` (`$clog2(REQ_N)` bits). On an error cycle, FIFO state still updates normally.
- Single-beat packets (last=1 on every beat) leave `keep` at 0 permanently. The arbiter then re-arbitrates every beat.

## Timing
- Reset values, applied when `rst_n=0` at a clock edge:
  - all pointers and levels = 0;
  - `in_rdy_o` = all-ones;
  - `arb_vld_o` = 0;
  - `lvl_o` = 0;
  - `arb_keep_o` = 0, `keep_id` = 0;
  - `err_o` = 0.
- Storage contents are not reset.
- Reset mid-packet discards all buffered beats and drops the lock. The next cycle behaves as after power-on reset.
- Push-to-visible latency is 1 cycle: a beat pushed at edge t gives `arb_vld_o[i]=1` in the cycle after t.
- Throughput is 1 push and 1 pop per channel per cycle. A FIFO at `DEPTH` under continuous pop sustains 1 beat/cycle.
- `arb_keep_o` updates on the edge of the popping handshake. This matches the arbiter latching its kept grant on the same edge.
- `lvl_o` is registered and reflects pushes and pops of the previous edge.

## Test plan
- Reset, then push `0x1111` (last=1) on ch2 at cycle 1 → `arb_vld_o=8'h04` at cycle 2, `arb_dat_o[2]=17'h11111`; pop at cycle 2 → `lvl_o[2]=0` and `arb_vld_o=0` at cycle 3.
- Fill ch0 with 4 beats without popping → `in_rdy_o[0]=0` and `lvl_o[0]=4`. Then push and pop ch5 every cycle for 10 cycles → `lvl_o[5]` stays 1; pops deliver data in push order, and wrap-around is exercised.
- Connect to the arbiter with ch1 and ch3 both holding 3-beat packets (last on beat 3) → the popped channel sequence is 1,1,1,3,3,3 or 3,3,3,1,1,1; `arb_keep_o=1` after beats 1 and 2 and 0 after beat 3.
- Ch4 packet: pop beat 1 (last=0), then leave ch4 empty for 5 cycles while ch6 is valid → no ch6 pop and `arb_keep_o` held at 1. Then push ch4's last beat → it pops, and ch6 pops next.
- Drive `arb_rdy_i=8'h03` with ch0 and ch1 both valid → `err_o=1` the next cycle and remains 1 until `rst_n=0`.
- Assert `rst_n=0` for 1 cycle with 3 beats in ch7 and `keep=1` → the next cycle shows `lvl_o[7]=0`, `arb_vld_o=0`, `arb_keep_o=0`, `in_rdy_o=8'hFF`.

Source files
------------

// File: rtl/stl_arb_ingress_queue.sv
// stl_arb_ingress_queue
// Per-requester ingress FIFOs feeding a matrix arbiter. Each channel's FIFO
// head is presented as a {last, payload} request. A packet lock (arb_keep_o)
// holds the arbiter on one channel until that packet's last beat pops.
// Illegal pop patterns (several pops at once, or a pop that breaks into a
// locked packet) raise a sticky error flag.
module stl_arb_ingress_queue #(
  parameter int REQ_N = 8,
  parameter int DAT_W = 16,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REQ_N-1:0]           in_vld_i,
  input  logic [REQ_N*DAT_W-1:0]     in_dat_i,
  input  logic [REQ_N-1:0]           in_last_i,
  output logic [REQ_N-1:0]           in_rdy_o,
  output logic [REQ_N-1:0]           arb_vld_o,
  output logic [REQ_N*(DAT_W+1)-1:0] arb_dat_o,
  input  logic [REQ_N-1:0]           arb_rdy_i,
  output logic                       arb_keep_o,
  output logic [REQ_N*LW-1:0]        lvl_o,
  output logic                       err_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int IDW = $clog2(REQ_N);
  localparam int BW  = DAT_W + 1;
  localparam logic [REQ_N-1:0] ONE_HOT0 = REQ_N'(1);

  // Per-channel storage and bookkeeping.
  logic [BW-1:0]    mem    [REQ_N][DEPTH];
  logic [PW-1:0]    wr_ptr [REQ_N];
  logic [PW-1:0]    rd_ptr [REQ_N];
  logic [LW-1:0]    lvl    [REQ_N];
  logic [BW-1:0]    head   [REQ_N];

  logic [REQ_N-1:0] push;
  logic [REQ_N-1:0] pop;

  // Packet lock and error state.
  logic             keep;
  logic [IDW-1:0]   keep_id;
  logic             err;

  // Pop decoding.
  logic             pop_any;
  logic             pop_multi;
  logic             pop_break;
  logic [IDW-1:0]   pop_idx;
  logic             pop_last;

  // Channel-facing outputs are decoded from registered level and read
  // pointer only, so ready has no path from arb_rdy_i.
  always_comb begin
    in_rdy_o  = '0;
    arb_vld_o = '0;
    arb_dat_o = '0;
    lvl_o     = '0;
    for (int i = 0; i < REQ_N; i++) begin
      head[i]                  = mem[i][rd_ptr[i]];
      in_rdy_o[i]              = (lvl[i] != LW'(DEPTH));
      arb_vld_o[i]             = (lvl[i] != '0);
      arb_dat_o[i*BW +: BW]    = head[i];
      lvl_o[i*LW +: LW]        = lvl[i];
    end
  end

  assign push       = in_vld_i & in_rdy_o;
  assign pop        = arb_vld_o & arb_rdy_i;
  assign arb_keep_o = keep;
  assign err_o      = err;

  // Identify the popping channel (lowest index if several pop, which is
  // itself an error) and flag illegal pop patterns.
  always_comb begin
    pop_idx = '0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      if (pop[i]) pop_idx = IDW'(i);
    end
    pop_any   = |pop;
    pop_multi = ((pop & (pop - ONE_HOT0)) != '0);
    pop_break = keep && ((pop & ~(ONE_HOT0 << keep_id)) != '0);
    pop_last  = head[pop_idx][DAT_W];
  end

  // Beat storage write port.
  // NOTE: storage has no reset; validity is carried by the level counters,
  // so resetting the array would only cost flops and reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_N; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {in_last_i[i], in_dat_i[i*DAT_W +: DAT_W]};
    end
  end

  // Per-channel pointers and occupancy; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REQ_N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        lvl[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_N; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   lvl[i] <= lvl[i] + LW'(1);
          2'b01:   lvl[i] <= lvl[i] - LW'(1);
          default: lvl[i] <= lvl[i];
        endcase
      end
    end
  end

  // Packet lock follows the last bit of each popped head; error is sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keep    <= 1'b0;
      keep_id <= '0;
      err     <= 1'b0;
    end else begin
      if (pop_any) begin
        keep    <= ~pop_last;
        keep_id <= pop_idx;
      end
      if (pop_multi || pop_break) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stl_arb_ingress_queue.sv
// Self-checking bench for stl_arb_ingress_queue. A queue-per-channel model
// tracks contents, lock and error; the bench also plays the arbiter role.
module tb_stl_arb_ingress_queue;

  localparam int REQ_N = 8;
  localparam int DAT_W = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int BW    = DAT_W + 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [REQ_N-1:0]        in_vld;
  logic [REQ_N*DAT_W-1:0]  in_dat;
  logic [REQ_N-1:0]        in_last;
  logic [REQ_N-1:0]        in_rdy;
  logic [REQ_N-1:0]        arb_vld;
  logic [REQ_N*BW-1:0]     arb_dat;
  logic [REQ_N-1:0]        arb_rdy;
  logic                    arb_keep;
  logic [REQ_N*LW-1:0]     lvl;
  logic                    err;

  always #5 clk = ~clk;

  stl_arb_ingress_queue #(
    .REQ_N(REQ_N), .DAT_W(DAT_W), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld_i   (in_vld),
    .in_dat_i   (in_dat),
    .in_last_i  (in_last),
    .in_rdy_o   (in_rdy),
    .arb_vld_o  (arb_vld),
    .arb_dat_o  (arb_dat),
    .arb_rdy_i  (arb_rdy),
    .arb_keep_o (arb_keep),
    .lvl_o      (lvl),
    .err_o      (err)
  );

  // Reference model state.
  logic [BW-1:0]    mq [REQ_N][$];
  bit               m_keep;
  int               m_kid;
  bit               m_err;
  logic [REQ_N-1:0] last_pop;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model using the inputs present at the edge.
  task automatic model_edge();
    logic [REQ_N-1:0] pv, pu;
    int first;
    if (!rst_n) begin
      for (int i = 0; i < REQ_N; i++) mq[i].delete();
      m_keep   = 0;
      m_kid    = 0;
      m_err    = 0;
      last_pop = '0;
    end else begin
      for (int i = 0; i < REQ_N; i++) begin
        pv[i] = (mq[i].size() != 0) && arb_rdy[i];
        pu[i] = in_vld[i] && (mq[i].size() != DEPTH);
      end
      if ($countones(pv) > 1) m_err = 1;
      if (m_keep) begin
        for (int i = 0; i < REQ_N; i++) if (pv[i] && i != m_kid) m_err = 1;
      end
      first = -1;
      for (int i = 0; i < REQ_N; i++) if (pv[i] && first < 0) first = i;
      if (first >= 0) begin
        m_keep = !mq[first][0][DAT_W];
        m_kid  = first;
      end
      for (int i = 0; i < REQ_N; i++) begin
        if (pv[i]) void'(mq[i].pop_front());
        if (pu[i]) mq[i].push_back({in_last[i], in_dat[i*DAT_W +: DAT_W]});
      end
      last_pop = pv;
    end
  endtask

  task automatic compare_all();
    logic [REQ_N-1:0] ev, er;
    for (int i = 0; i < REQ_N; i++) begin
      ev[i] = (mq[i].size() != 0);
      er[i] = (mq[i].size() != DEPTH);
    end
    check("arb_vld", 32'(arb_vld), 32'(ev));
    check("in_rdy", 32'(in_rdy), 32'(er));
    check("keep", 32'(arb_keep), 32'(m_keep));
    check("err", 32'(err), 32'(m_err));
    for (int i = 0; i < REQ_N; i++) begin
      check($sformatf("lvl[%0d]", i), 32'(lvl[i*LW +: LW]), 32'(mq[i].size()));
      if (mq[i].size() != 0)
        check($sformatf("dat[%0d]", i), 32'(arb_dat[i*BW +: BW]), 32'(mq[i][0]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Arbiter behaviour: honour the lock, otherwise grant one valid channel.
  task automatic arb_pick(input bit rnd, output logic [REQ_N-1:0] r);
    int  s;
    int  c;
    bit  found;
    r = '0;
    if (m_keep) begin
      if (mq[m_kid].size() != 0) r[m_kid] = 1'b1;
    end else begin
      s     = rnd ? int'($urandom_range(0, REQ_N - 1)) : 0;
      found = 0;
      for (int k = 0; k < REQ_N; k++) begin
        c = (s + k) % REQ_N;
        if (!found && mq[c].size() != 0) begin
          r[c]  = 1'b1;
          found = 1;
        end
      end
    end
  endtask

  initial begin
    logic [REQ_N-1:0] r;
    int es [6];
    es = '{1, 1, 1, 3, 3, 3};

    rst_n   = 1'b0;
    in_vld  = '0;
    in_dat  = '0;
    in_last = '0;
    arb_rdy = '0;

    // Reset state.
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_rdy", 32'(in_rdy), 32'hFF);
    check("rst_vld", 32'(arb_vld), 32'h00);

    // Single beat on ch2: visible next cycle, gone after its pop.
    in_vld[2] = 1'b1;
    in_last[2] = 1'b1;
    in_dat[2*DAT_W +: DAT_W] = 16'h1111;
    tick();
    in_vld = '0;
    in_last = '0;
    check("ch2_vld", 32'(arb_vld), 32'h04);
    check("ch2_dat", 32'(arb_dat[2*BW +: BW]), 32'h11111);
    arb_rdy = 8'h04;
    tick();
    arb_rdy = '0;
    check("ch2_lvl", 32'(lvl[2*LW +: LW]), 32'd0);
    check("ch2_empty", 32'(arb_vld), 32'h00);

    // Fill ch0 and attempt one push while full (must be dropped).
    in_vld[0] = 1'b1;
    in_last[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_dat[0 +: DAT_W] = (k == 4) ? 16'hDEAD : 16'h0A00 + 16'(k);
      tick();
    end
    in_vld = '0;
    check("ch0_full_rdy", 32'(in_rdy[0]), 32'd0);
    check("ch0_full_lvl", 32'(lvl[0 +: LW]), 32'd4);

    // Ch5 streaming: one push, then 10 cycles of push+pop, wrapping pointers.
    in_vld[5] = 1'b1;
    in_last[5] = 1'b1;
    in_dat[5*DAT_W +: DAT_W] = 16'h5000;
    tick();
    for (int k = 1; k <= 10; k++) begin
      in_dat[5*DAT_W +: DAT_W] = 16'h5000 + 16'(k);
      arb_rdy = 8'h20;
      tick();
      check("ch5_lvl", 32'(lvl[5*LW +: LW]), 32'd1);
    end
    in_vld = '0;
    in_last = '0;
    tick();
    arb_rdy = 8'h01;
    for (int k = 0; k < 4; k++) tick();
    arb_rdy = '0;
    check("drained", 32'(arb_vld), 32'h00);

    // Ch1 and ch3 each hold a 3-beat packet; no interleaving allowed.
    in_vld = 8'h0A;
    for (int b = 0; b < 3; b++) begin
      in_last = (b == 2) ? 8'h0A : 8'h00;
      in_dat[1*DAT_W +: DAT_W] = 16'h1100 + 16'(b);
      in_dat[3*DAT_W +: DAT_W] = 16'h3300 + 16'(b);
      tick();
    end
    in_vld = '0;
    in_last = '0;
    for (int k = 0; k < 6; k++) begin
      arb_pick(1'b0, r);
      arb_rdy = r;
      tick();
      check("pkt_seq", 32'(last_pop), 32'(8'(1) << es[k]));
      check("pkt_keep", 32'(arb_keep), (k % 3 != 2) ? 32'd1 : 32'd0);
    end
    arb_rdy = '0;

    // Ch4 drains mid-packet while ch6 waits; lock must hold.
    in_vld = 8'h50;
    in_last = 8'h40;
    in_dat[4*DAT_W +: DAT_W] = 16'h4A01;
    in_dat[6*DAT_W +: DAT_W] = 16'h6B01;
    tick();
    in_vld = '0;
    in_last = '0;
    arb_rdy = 8'h10;
    tick();
    for (int k = 0; k < 5; k++) begin
      arb_pick(1'b0, r);
      arb_rdy = r;
      tick();
      check("hold_keep", 32'(arb_keep), 32'd1);
      check("hold_ch6", 32'(lvl[6*LW +: LW]), 32'd1);
    end
    arb_rdy = '0;
    in_vld = 8'h10;
    in_last = 8'h10;
    in_dat[4*DAT_W +: DAT_W] = 16'h4A02;
    tick();
    in_vld = '0;
    in_last = '0;
    arb_pick(1'b0, r);
    arb_rdy = r;
    tick();
    check("ch4_last_pop", 32'(last_pop), 32'h10);
    check("ch4_unlock", 32'(arb_keep), 32'd0);
    arb_pick(1'b0, r);
    arb_rdy = r;
    tick();
    check("ch6_pop", 32'(last_pop), 32'h40);
    arb_rdy = '0;

    // Two simultaneous pops raise a sticky error.
    in_vld = 8'h03;
    in_last = 8'h03;
    tick();
    in_vld = '0;
    in_last = '0;
    arb_rdy = 8'h03;
    tick();
    arb_rdy = '0;
    check("err_set", 32'(err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("err_hold", 32'(err), 32'd1);
    end

    // Reset with 3 beats in ch7 and the lock held.
    in_vld = 8'h80;
    for (int k = 0; k < 4; k++) begin
      in_dat[7*DAT_W +: DAT_W] = 16'h7700 + 16'(k);
      tick();
    end
    in_vld = '0;
    arb_rdy = 8'h80;
    tick();
    arb_rdy = '0;
    check("pre_rst_lvl7", 32'(lvl[7*LW +: LW]), 32'd3);
    check("pre_rst_keep", 32'(arb_keep), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_lvl7", 32'(lvl[7*LW +: LW]), 32'd0);
    check("rst_vld2", 32'(arb_vld), 32'h00);
    check("rst_keep", 32'(arb_keep), 32'd0);
    check("rst_rdy2", 32'(in_rdy), 32'hFF);
    check("rst_err", 32'(err), 32'd0);

    // Randomized traffic under a lock-respecting arbiter.
    for (int k = 0; k < 400; k++) begin
      in_vld  = REQ_N'($urandom);
      in_dat  = {$urandom, $urandom, $urandom, $urandom};
      in_last = REQ_N'($urandom) | REQ_N'($urandom);
      if ($urandom_range(0, 4) == 0) arb_rdy = '0;
      else begin
        arb_pick(1'b1, r);
        arb_rdy = r;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
